// File: rtl/gpr_file_mp.sv
// gpr_file_mp: parametrised multi-port general-purpose register file.
//   - N_RD combinational read ports, each with data and busy flag
//   - write port A (ALU writeback) and write port B (load writeback, wins on collision)
//   - per-register busy scoreboard set by load issue, cleared by load writeback
//   - register 0 is hardwired to zero and is never marked busy
// Optional feature macro: GPR_BYPASS_EN enables same-cycle write-to-read forwarding.
module gpr_file_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int N_RD   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    output logic [N_RD-1:0]          rd_busy,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic                     busy_any
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic [DEPTH-1:0]  busy_r;

    logic wa_hit_s;
    logic wb_hit_s;
    logic issue_hit_s;

    // Writes and issues aimed at register 0 are discarded up front.
    assign wa_hit_s    = wa_en    && (wa_addr    != {ADDR_W{1'b0}});
    assign wb_hit_s    = wb_en    && (wb_addr    != {ADDR_W{1'b0}});
    assign issue_hit_s = issue_en && (issue_addr != {ADDR_W{1'b0}});

    // Register array update: port B overrides port A on the same address; r0 stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wb_hit_s && (wb_addr == ADDR_W'(i))) begin
                    regs_r[i] <= wb_data;
                end else if (wa_hit_s && (wa_addr == ADDR_W'(i))) begin
                    regs_r[i] <= wa_data;
                end
            end
        end
    end

    // Busy scoreboard: a new issue supersedes a same-cycle writeback clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= {DEPTH{1'b0}};
        end else begin
            busy_r[0] <= 1'b0;
            for (int i = 1; i < DEPTH; i++) begin
                if (issue_hit_s && (issue_addr == ADDR_W'(i))) begin
                    busy_r[i] <= 1'b1;
                end else if (wb_en && (wb_addr == ADDR_W'(i))) begin
                    busy_r[i] <= 1'b0;
                end
            end
        end
    end

    assign busy_any = |busy_r;

    for (genvar p = 0; p < N_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr_s;
        logic [DATA_W-1:0] data_s;
        logic              busy_s;

        assign addr_s = rd_addr[p*ADDR_W +: ADDR_W];

        // Combinational read of one port, optionally forwarding same-cycle writes.
        always_comb begin
            data_s = regs_r[addr_s];
            busy_s = busy_r[addr_s];
`ifdef GPR_BYPASS_EN
            if (wb_hit_s && (wb_addr == addr_s)) begin
                data_s = wb_data;
            end else if (wa_hit_s && (wa_addr == addr_s)) begin
                data_s = wa_data;
            end else begin
                data_s = regs_r[addr_s];
            end
            if (wb_hit_s && (wb_addr == addr_s) &&
                !(issue_hit_s && (issue_addr == addr_s))) begin
                busy_s = 1'b0;
            end else begin
                busy_s = busy_r[addr_s];
            end
`endif
        end

        assign rd_data[p*DATA_W +: DATA_W] = data_s;
        assign rd_busy[p]                  = busy_s;
    end

endmodule

// File: doc/gpr_file_mp.md
# gpr_file_mp

Parametrised multi-port general-purpose register file for the CPU datapath. It replaces the fixed 32×32 two-read/one-write file and supports:
- a configurable number of combinational read ports;
- two write ports: ALU writeback and load writeback;
- a per-register busy scoreboard, so decode can stall on load-use hazards.

Register 0 is hardwired to zero. All state clears on reset.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- N_RD, 2, number of read ports (1..4)

Ports:
- clk  in  1  clock, rising edge active
- rst  in  1  reset, asynchronous, active-high
- rd_addr  in  N_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  N_RD*DATA_W  read data; port i at bits [i*DATA_W +: DATA_W]
- rd_busy  out  N_RD  busy flag of the register addressed by each read port
- wa_en  in  1  write port A (ALU writeback) enable
- wa_addr  in  ADDR_W  write port A address
- wa_data  in  DATA_W  write port A data
- wb_en  in  1  write port B (load writeback) enable; also clears busy
- wb_addr  in  ADDR_W  write port B address
- wb_data  in  DATA_W  write port B data
- issue_en  in  1  load issued; marks destination busy
- issue_addr  in  ADDR_W  load destination register
- busy_any  out  1  OR of all busy bits

## Operation
Storage:
- Array of 2**ADDR_W registers of DATA_W bits.
- Busy vector of 2**ADDR_W bits.

Reset (rst high, asynchronous):
- All registers clear to 0; all busy bits clear to 0.
- Resulting outputs: rd_data all 0, rd_busy 0, busy_any 0.
- Any in-flight write is discarded.

Writes (rising clk, rst low):
- Port A writes when wa_en = 1 and wa_addr != 0.
- Port B writes when wb_en = 1 and wb_addr != 0.
- If both ports target the same nonzero address in the same cycle, port B's data is stored. Port A's write is dropped.
- Writes to address 0 are ignored. Register 0 always reads 0.

Scoreboard (rising clk):
- issue_en with issue_addr != 0 sets busy[issue_addr].
- wb_en clears busy[wb_addr].
- Set and clear on the same address in the same cycle: set wins (a new load supersedes the old one).
- Port A does not touch busy bits.
- busy[0] is never set.
- Issuing to an address that is already busy leaves it busy (idempotent).

Reads (combinational, any time):
- rd_data[i] = reg[rd_addr[i]].
- rd_busy[i] = busy[rd_addr[i]].
- Address 0 returns data 0 and busy 0.

## Timing
- Write latency: data written at edge N is visible on rd_data after edge N (same cycle as the write → old value unless GPR_BYPASS_EN is defined).
- Busy set by issue at edge N: rd_busy is 1 from after edge N.
- Busy clear by wb at edge N: rd_busy is 0 from after edge N.
- Read path is purely combinational. There is no read latency and no enable.
- Reset assertion takes effect immediately, with no clock required. Deassertion is synchronous to the upstream reset synchroniser.

## Configuration
Macro: GPR_BYPASS_EN.
- Defined: write-to-read forwarding is active. A read port whose address matches an active same-cycle write returns that write data.
  - Priority: port B, then port A, then stored value.
  - rd_busy[i] also reads 0 if wb_en hits the same address in that cycle, unless issue_en sets it in the same cycle.
  - Address 0 is never forwarded.
- Not defined: reads return stored array contents and the registered busy bits only. A same-cycle write is visible from the next cycle.

## Test plan
- Reset: write 0xDEADBEEF to r5, then pulse rst mid-cycle → rd_data for r5 is 0 immediately, without waiting for a clock edge; busy_any = 0.
- r0 protection: wa_en writes 0x12345678 to r0, and issue_en targets r0 → r0 reads 0; rd_busy = 0.
- Write collision: wa and wb both write r7 in the same cycle (A = 0x1111, B = 0x2222) → r7 reads 0x2222 next cycle.
- Scoreboard: issue r9 at cycle 1 → rd_busy = 1 from cycle 2. At cycle 4, wb writes r9 = 0xABCD and issue_en re-targets r9 → r9 = 0xABCD and still busy. At cycle 5, wb clears it → busy 0, busy_any 0.
- Bypass: with GPR_BYPASS_EN, wa writes r3 = 0x55 while port 0 reads r3 → rd_data = 0x55 in the same cycle. Without the macro → old value in that cycle, 0x55 next cycle.
- Parameters: DATA_W = 16, ADDR_W = 3, N_RD = 4. Write distinct values to r1..r7, then read them on all four ports → every port returns the correct value; r0 reads 0.
